int_ctrl: RTL and testbench

Interrupt controller that consumes the request lines raised by the peripheral blocks (timer `int_timer`, LCD, serial, joypad). It owns the IF register at FF0F and the IE register at FFFF on the CPU bus, and presents a prioritized request/vector/acknowledge handshake to the CPU core. It also provides a halt-wake indication that is independent of IME.

---
 rtl/int_ctrl_if.sv | 22 ++
 rtl/int_ctrl.sv | 121 ++++++++++++
 tb/tb_int_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_if.sv
// CPU-side bus and dispatch handshake of the interrupt controller.
// The tri-state data bus stays a plain inout port on the controller.
interface int_ctrl_if;
  logic [15:0] a;
  logic        cpu_wr;
  logic        cpu_rd;
  logic        ime;
  logic        cpu_int_ack;
  logic        cpu_int_req;
  logic [7:0]  cpu_int_vec;
  logic        int_pending;

  modport slave (
    input  a, cpu_wr, cpu_rd, ime, cpu_int_ack,
    output cpu_int_req, cpu_int_vec, int_pending
  );

  modport master (
    output a, cpu_wr, cpu_rd, ime, cpu_int_ack,
    input  cpu_int_req, cpu_int_vec, int_pending
  );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: IF (FF0F) / IE (FFFF) registers, rising-edge capture
// of five sources, fixed lowest-index-first priority and a REQ/ack dispatch
// handshake to the CPU. int_pending wakes from halt regardless of IME.
module int_ctrl (
  input  logic       boga1mhz,
  input  logic       reset,
  int_ctrl_if.slave  bus,
  inout  wire  [7:0] d,
  input  logic       int_vblank,
  input  logic       int_stat,
  input  logic       int_timer,
  input  logic       int_serial,
  input  logic       int_joypad
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t     state, state_nxt;
  logic [4:0] src, src_q, rise, pending, ack_clr;
  logic [4:0] if_r, if_nxt;
  logic [7:0] ie_r;
  logic [7:0] vec_cur, vec_q, vec_nxt;
  logic [2:0] win_idx;
  logic       pend_q;
  logic       wr_if, wr_ie, rd_if, rd_ie, ack_take;
  logic       req_o;
  logic [7:0] vec_o;

  assign src     = {int_joypad, int_serial, int_timer, int_stat, int_vblank};
  assign rise    = src & ~src_q;
  assign pending = if_r & ie_r[4:0];

  assign wr_if = bus.cpu_wr && (bus.a == 16'hFF0F);
  assign wr_ie = bus.cpu_wr && (bus.a == 16'hFFFF);
  assign rd_if = bus.cpu_rd && (bus.a == 16'hFF0F);
  assign rd_ie = bus.cpu_rd && (bus.a == 16'hFFFF);

  // Read data is combinational; bus is released whenever no register is hit.
  assign d = rd_if ? {3'b111, if_r} :
             rd_ie ? ie_r           : 8'bz;

  // Lowest set pending bit wins.
  always_comb begin
    win_idx = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (pending[i]) win_idx = i[2:0];
  end

  assign vec_cur  = (pending == 5'd0) ? 8'h00 : 8'h40 + {2'b00, win_idx, 3'b000};
  assign ack_take = (state == REQ) && bus.cpu_int_ack;
  // A cancelled dispatch (nothing pending at ack) clears nothing.
  assign ack_clr  = (ack_take && (pending != 5'd0)) ? (5'b00001 << win_idx) : 5'b00000;

  // Per-bit IF next state: new edge beats ack clear, which beats CPU write.
  always_comb begin
    if_nxt = if_r;
    for (int i = 0; i < 5; i++) begin
      if (rise[i])         if_nxt[i] = 1'b1;
      else if (ack_clr[i]) if_nxt[i] = 1'b0;
      else if (wr_if)      if_nxt[i] = d[i];
    end
  end

  // Register file, edge history and registered halt-wake flag.
  always_ff @(posedge boga1mhz) begin
    if (reset) begin
      if_r   <= 5'd0;
      ie_r   <= 8'h00;
      src_q  <= 5'd0;
      pend_q <= 1'b0;
    end else begin
      if_r   <= if_nxt;
      src_q  <= src;
      pend_q <= |pending;
      if (wr_ie) ie_r <= d;
    end
  end

  // Dispatch state and the vector latched at acknowledge.
  always_ff @(posedge boga1mhz) begin
    if (reset) begin
      state <= IDLE;
      vec_q <= 8'h00;
    end else begin
      state <= state_nxt;
      vec_q <= vec_nxt;
    end
  end

  // Dispatch next state and outputs; ack has precedence over an IME drop.
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_q;
    req_o     = 1'b0;
    vec_o     = vec_cur;
    case (state)
      IDLE: begin
        if (bus.ime && (pending != 5'd0)) state_nxt = REQ;
      end
      REQ: begin
        req_o = 1'b1;
        if (bus.cpu_int_ack) begin
          state_nxt = HOLD;
          vec_nxt   = vec_cur;
        end else if (!bus.ime) begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        vec_o     = vec_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cpu_int_req = req_o;
  assign bus.cpu_int_vec = vec_o;
  assign bus.int_pending = pend_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed vector table, two hand sequences for reset and
// stray-ack corners, then randomized traffic against a behavioural model.
module tb_int_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_ctrl_if bus();
  wire  [7:0] d;
  logic [7:0] drv_d;
  logic       drv_en;
  logic [4:0] s;
  assign d = drv_en ? drv_d : 8'bz;

  int_ctrl dut (
    .boga1mhz  (clk),
    .reset     (rst),
    .bus       (bus),
    .d         (d),
    .int_vblank(s[0]),
    .int_stat  (s[1]),
    .int_timer (s[2]),
    .int_serial(s[3]),
    .int_joypad(s[4])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [4:0] m_if, m_prev;
  logic [7:0] m_ie, m_hvec;
  bit         m_req, m_hold, m_pq;

  function automatic logic [7:0] vec_of(input logic [4:0] p);
    for (int i = 0; i < 5; i++)
      if (p[i]) return 8'h40 + 8'(8 * i);
    return 8'h00;
  endfunction

  function automatic int low_idx(input logic [4:0] p);
    for (int i = 0; i < 5; i++)
      if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    logic [4:0] pend, nif;
    int w;
    if (rst) begin
      m_if = 0; m_prev = 0; m_ie = 0; m_hvec = 0;
      m_req = 0; m_hold = 0; m_pq = 0;
      return;
    end
    pend = m_if & m_ie[4:0];
    w    = low_idx(pend);
    nif  = m_if;
    if (bus.cpu_wr && bus.a == 16'hFF0F) nif = drv_d[4:0];
    if (m_req && bus.cpu_int_ack && w >= 0) nif[w] = 1'b0;
    nif = nif | (s & ~m_prev);
    if (bus.cpu_wr && bus.a == 16'hFFFF) m_ie = drv_d;
    m_pq = (pend != 0);
    if (m_hold) begin
      m_hold = 0;
    end else if (m_req) begin
      if (bus.cpu_int_ack) begin
        m_req = 0; m_hold = 1; m_hvec = vec_of(pend);
      end else if (!bus.ime) m_req = 0;
    end else if (bus.ime && pend != 0) begin
      m_req = 1;
    end
    m_prev = s;
    m_if   = nif;
  endtask

  task automatic drive(input logic r, input logic [4:0] src, input logic ime,
                       input logic ack, input logic wr, input logic rd,
                       input logic [15:0] a, input logic [7:0] dv);
    rst = r; s = src; bus.ime = ime; bus.cpu_int_ack = ack;
    bus.cpu_wr = wr; bus.cpu_rd = rd; bus.a = a; drv_d = dv; drv_en = wr;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic r; logic [4:0] src; logic ime, ack, wr, rd;
    logic [15:0] a; logic [7:0] dv;
    logic e_req; logic [7:0] e_vec; logic e_pend, chk_d; logic [7:0] e_d;
  } row_t;
  row_t tbl[$];

  task automatic row(input logic r, input logic [4:0] src, input logic ime,
                     input logic ack, input logic wr, input logic rd,
                     input logic [15:0] a, input logic [7:0] dv,
                     input logic e_req, input logic [7:0] e_vec,
                     input logic e_pend, input logic chk_d, input logic [7:0] e_d);
    row_t t;
    t.r = r; t.src = src; t.ime = ime; t.ack = ack; t.wr = wr; t.rd = rd;
    t.a = a; t.dv = dv; t.e_req = e_req; t.e_vec = e_vec; t.e_pend = e_pend;
    t.chk_d = chk_d; t.e_d = e_d;
    tbl.push_back(t);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
    //   r src   ime ack wr rd addr      data   req vec    pnd chk d
    row(1, 5'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 8'h00); // reset
    row(1, 5'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 8'h00);
    row(0, 5'h00, 0, 0, 0, 1, 16'hFF0F, 8'h00, 0, 8'h00, 0, 1, 8'hE0);
    row(0, 5'h00, 0, 0, 0, 1, 16'hFFFF, 8'h00, 0, 8'h00, 0, 1, 8'h00);
    // timer dispatch
    row(0, 5'h00, 0, 0, 1, 0, 16'hFFFF, 8'h04, 0, 8'h00, 0, 0, 8'h00);
    row(0, 5'h04, 1, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h50, 0, 0, 8'h00);
    row(0, 5'h00, 1, 0, 0, 0, 16'h0000, 8'h00, 1, 8'h50, 1, 0, 8'h00);
    row(0, 5'h00, 1, 1, 0, 1, 16'hFF0F, 8'h00, 0, 8'h50, 1, 1, 8'hE0);
    row(0, 5'h00, 1, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 8'h00);
    // priority: stat + serial together
    row(0, 5'h00, 1, 0, 1, 0, 16'hFFFF, 8'h1F, 0, 8'h00, 0, 0, 8'h00);
    row(0, 5'h0A, 1, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h48, 0, 0, 8'h00);
    row(0, 5'h0A, 1, 0, 0, 0, 16'h0000, 8'h00, 1, 8'h48, 1, 0, 8'h00);
    row(0, 5'h0A, 1, 1, 0, 0, 16'h0000, 8'h00, 0, 8'h48, 1, 0, 8'h00);
    row(0, 5'h00, 1, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h58, 1, 0, 8'h00);
    row(0, 5'h00, 1, 0, 0, 0, 16'h0000, 8'h00, 1, 8'h58, 1, 0, 8'h00);
    row(0, 5'h00, 1, 1, 0, 1, 16'hFF0F, 8'h00, 0, 8'h58, 1, 1, 8'hE0);
    row(0, 5'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 8'h00);
    // write 0 to IF colliding with a joypad edge
    row(0, 5'h10, 0, 0, 1, 0, 16'hFF0F, 8'h00, 0, 8'h60, 0, 0, 8'h00);
    row(0, 5'h00, 0, 0, 0, 1, 16'hFF0F, 8'h00, 0, 8'h60, 1, 1, 8'hF0);
    // cancelled dispatch
    row(0, 5'h00, 0, 0, 1, 0, 16'hFF0F, 8'h00, 0, 8'h00, 1, 0, 8'h00);
    row(0, 5'h01, 1, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h40, 0, 0, 8'h00);
    row(0, 5'h00, 1, 0, 0, 0, 16'h0000, 8'h00, 1, 8'h40, 1, 0, 8'h00);
    row(0, 5'h00, 1, 0, 1, 0, 16'hFFFF, 8'h00, 1, 8'h00, 1, 0, 8'h00);
    row(0, 5'h00, 1, 1, 0, 1, 16'hFF0F, 8'h00, 0, 8'h00, 0, 1, 8'hE1);
    row(0, 5'h00, 1, 0, 0, 1, 16'hFF0F, 8'h00, 0, 8'h00, 0, 1, 8'hE1);
    // halt wake with IME off
    row(0, 5'h00, 0, 0, 1, 0, 16'hFF0F, 8'h00, 0, 8'h00, 0, 0, 8'h00);
    row(0, 5'h00, 0, 0, 1, 0, 16'hFFFF, 8'h01, 0, 8'h00, 0, 0, 8'h00);
    row(0, 5'h01, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h40, 0, 0, 8'h00);
    row(0, 5'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h40, 1, 0, 8'h00);
    row(0, 5'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h40, 1, 0, 8'h00);
    row(1, 5'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 8'h00);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].src, tbl[i].ime, tbl[i].ack, tbl[i].wr, tbl[i].rd,
            tbl[i].a, tbl[i].dv);
      cycle();
      chk($sformatf("row%0d req", i), bus.cpu_int_req, tbl[i].e_req);
      chk($sformatf("row%0d vec", i), bus.cpu_int_vec, tbl[i].e_vec);
      chk($sformatf("row%0d pend", i), bus.int_pending, tbl[i].e_pend);
      if (tbl[i].chk_d) chk($sformatf("row%0d rd", i), d, tbl[i].e_d);
    end

    // reset while in REQ drops the request and clears IF
    drive(0, 5'h00, 1, 0, 1, 0, 16'hFFFF, 8'h01); cycle();
    drive(0, 5'h01, 1, 0, 0, 0, 16'h0000, 8'h00); cycle();
    drive(0, 5'h00, 1, 0, 0, 0, 16'h0000, 8'h00); cycle();
    chk("seqA req", bus.cpu_int_req, 1);
    chk("seqA vec", bus.cpu_int_vec, 8'h40);
    drive(1, 5'h00, 1, 0, 0, 0, 16'h0000, 8'h00); cycle();
    chk("seqA rst req", bus.cpu_int_req, 0);
    chk("seqA rst vec", bus.cpu_int_vec, 8'h00);
    drive(0, 5'h00, 1, 0, 0, 1, 16'hFF0F, 8'h00); cycle();
    chk("seqA rd IF", d, 8'hE0);

    // ack outside REQ is ignored
    drive(0, 5'h00, 0, 0, 1, 0, 16'hFFFF, 8'h01); cycle();
    drive(0, 5'h01, 0, 0, 0, 0, 16'h0000, 8'h00); cycle();
    drive(0, 5'h00, 0, 1, 0, 0, 16'h0000, 8'h00); cycle();
    chk("seqB req", bus.cpu_int_req, 0);
    drive(0, 5'h00, 0, 0, 0, 1, 16'hFF0F, 8'h00); cycle();
    chk("seqB rd IF", d, 8'hE1);
    chk("seqB pend", bus.int_pending, 1);

    // randomized traffic vs model
    drive(1, 5'h00, 0, 0, 0, 0, 16'h0000, 8'h00); cycle(); cycle();
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] ra;
      logic [4:0]  ns;
      int op;
      op = int'($urandom_range(0, 5));
      case ($urandom_range(0, 2))
        0:       ra = 16'hFF0F;
        1:       ra = 16'hFFFF;
        default: ra = 16'hFF0E;
      endcase
      ns = s ^ (5'($urandom) & 5'($urandom));
      drive(($urandom_range(0, 99) == 0), ns, ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) == 0), (op == 0), (op == 1), ra, 8'($urandom));
      cycle();
      chk("rnd req", bus.cpu_int_req, m_req);
      chk("rnd vec", bus.cpu_int_vec, m_hold ? m_hvec : vec_of(m_if & m_ie[4:0]));
      chk("rnd pend", bus.int_pending, m_pq);
      if (bus.cpu_rd && ra == 16'hFF0F) chk("rnd rd IF", d, {3'b111, m_if});
      if (bus.cpu_rd && ra == 16'hFFFF) chk("rnd rd IE", d, m_ie);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
